// File: rtl/seq_identifier_if.sv
// Stream and status bundle for the sequence identifier.
// The master drives the term stream and the slave reports the identification state.
interface seq_identifier_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] cand;
    logic       locked;
    logic [2:0] match_id;
    logic       fail;
    logic [7:0] count;

    modport master (output start, in_valid, in_data,
                    input  cand, locked, match_id, fail, count);
    modport slave  (input  start, in_valid, in_data,
                    output cand, locked, match_id, fail, count);
endinterface

// File: rtl/seq_identifier.sv
// Identifies which of eight mod-256 integer sequences an 8-bit term stream follows,
// by running eight reference generators in lockstep and pruning a candidate mask.
module seq_identifier #(
    parameter int unsigned CONFIRM = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_identifier_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAIL} state_e;

    state_e     state_q, state_d;
    logic [7:0] cand_q, cand_d, count_q, count_d;
    logic       locked_q, locked_d, fail_q, fail_d;
    logic [2:0] match_id_q, match_id_d;
    // Generator state: shared index, exp3, fib pair, pell pair, lucas pair, padovan triple, sylvester
    logic [7:0] idx_q, idx_d, exp_q, exp_d, syl_q, syl_d;
    logic [7:0] fa_q, fa_d, fb_q, fb_d, pa_q, pa_d, pb_q, pb_d;
    logic [7:0] la_q, la_d, lb_q, lb_d, da_q, da_d, db_q, db_d, dc_q, dc_d;

    logic [7:0][7:0] term;
    logic [7:0]      hit;
    logic [8:0]      np1;
    logic            one_hot;

    always_comb begin
        np1     = {1'b0, idx_q} + 9'd1;
        term[0] = idx_q * idx_q;
        // n(n+1)/2 halves whichever factor is even so the product never needs a ninth bit
        term[2] = idx_q[0] ? idx_q * np1[8:1] : {1'b0, idx_q[7:1]} * np1[7:0];
        term[1] = exp_q;
        term[3] = fa_q;
        term[4] = pa_q;
        term[5] = la_q;
        term[6] = da_q;
        term[7] = syl_q;
        for (int k = 0; k < 8; k++) hit[k] = (term[k] == bus.in_data);
    end

    always_comb begin
        state_d = state_q;  cand_d = cand_q;  count_d = count_q;
        idx_d = idx_q;  exp_d = exp_q;  syl_d = syl_q;
        fa_d = fa_q;  fb_d = fb_q;  pa_d = pa_q;  pb_d = pb_q;
        la_d = la_q;  lb_d = lb_q;  da_d = da_q;  db_d = db_q;  dc_d = dc_q;
        one_hot = 1'b0;
        if (bus.start) begin
            state_d = IDLE;  cand_d = 8'hFF;  count_d = 8'd0;
            idx_d = 8'd0;  exp_d = 8'd1;  syl_d = 8'd2;
            fa_d = 8'd1;  fb_d = 8'd1;  pa_d = 8'd0;  pb_d = 8'd1;
            la_d = 8'd2;  lb_d = 8'd1;  da_d = 8'd1;  db_d = 8'd1;  dc_d = 8'd1;
        end else if (bus.in_valid && state_q != FAIL) begin
            cand_d  = cand_q & hit;
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            idx_d   = idx_q + 8'd1;
            exp_d   = exp_q * 8'd3;
            syl_d   = syl_q * (syl_q - 8'd1) + 8'd1;
            fa_d = fb_q;  fb_d = fa_q + fb_q;
            pa_d = pb_q;  pb_d = {pb_q[6:0], 1'b0} + pa_q;
            la_d = lb_q;  lb_d = la_q + lb_q;
            da_d = db_q;  db_d = dc_q;  dc_d = da_q + db_q;
            one_hot = (cand_d != 8'd0) && ((cand_d & (cand_d - 8'd1)) == 8'd0);
            if (cand_d == 8'd0)                              state_d = FAIL;
            else if (one_hot && 32'(count_d) >= CONFIRM)     state_d = LOCKED;
            else                                             state_d = TRACK;
        end
        locked_d   = (state_d == LOCKED);
        fail_d     = (state_d == FAIL);
        match_id_d = 3'd0;
        if (locked_d)
            for (int k = 0; k < 8; k++)
                if (cand_d[k]) match_id_d = match_id_d | 3'(k);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;  cand_q <= 8'hFF;  count_q <= 8'd0;
            locked_q <= 1'b0;  fail_q <= 1'b0;  match_id_q <= 3'd0;
            idx_q <= 8'd0;  exp_q <= 8'd1;  syl_q <= 8'd2;
            fa_q <= 8'd1;  fb_q <= 8'd1;  pa_q <= 8'd0;  pb_q <= 8'd1;
            la_q <= 8'd2;  lb_q <= 8'd1;  da_q <= 8'd1;  db_q <= 8'd1;  dc_q <= 8'd1;
        end else begin
            state_q <= state_d;  cand_q <= cand_d;  count_q <= count_d;
            locked_q <= locked_d;  fail_q <= fail_d;  match_id_q <= match_id_d;
            idx_q <= idx_d;  exp_q <= exp_d;  syl_q <= syl_d;
            fa_q <= fa_d;  fb_q <= fb_d;  pa_q <= pa_d;  pb_q <= pb_d;
            la_q <= la_d;  lb_q <= lb_d;  da_q <= da_d;  db_q <= db_d;  dc_q <= dc_d;
        end
    end

    assign bus.cand     = cand_q;
    assign bus.locked   = locked_q;
    assign bus.match_id = match_id_q;
    assign bus.fail     = fail_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_seq_identifier.sv
// Directed bench for seq_identifier: hand-computed candidate masks for each sequence,
// failure stickiness, lock loss, start/valid collision and asynchronous reset.
module tb_seq_identifier;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seq_identifier_if bus ();

    seq_identifier #(.CONFIRM(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Presents one term for a single cycle; on return the outputs reflect it.
    task automatic sample(input logic [7:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk8({tag, "_cand"},  bus.cand, 8'hFF);
        chk1({tag, "_lock"},  bus.locked, 1'b0);
        chk8({tag, "_mid"},   {5'd0, bus.match_id}, 8'd0);
        chk1({tag, "_fail"},  bus.fail, 1'b0);
        chk8({tag, "_count"}, bus.count, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst");

        // squares
        sample(8'd0);  chk8("sq1_cand", bus.cand, 8'h15);
        sample(8'd1);  chk8("sq2_cand", bus.cand, 8'h15);
        sample(8'd4);  chk8("sq3_cand", bus.cand, 8'h01);  chk1("sq3_lock", bus.locked, 1'b0);
        sample(8'd9);  chk8("sq4_cand", bus.cand, 8'h01);  chk1("sq4_lock", bus.locked, 1'b1);
        chk8("sq4_mid", {5'd0, bus.match_id}, 8'd0);       chk8("sq4_count", bus.count, 8'd4);
        repeat (3) @(negedge clk);
        chk8("hold_count", bus.count, 8'd4);               chk1("hold_lock", bus.locked, 1'b1);

        // padovan
        restart();     chk_idle("st1");
        sample(8'd1);  chk8("pd1_cand", bus.cand, 8'h4A);
        sample(8'd1);  chk8("pd2_cand", bus.cand, 8'h48);
        sample(8'd1);  chk8("pd3_cand", bus.cand, 8'h40);  chk1("pd3_lock", bus.locked, 1'b0);
        sample(8'd2);  chk8("pd4_cand", bus.cand, 8'h40);  chk1("pd4_lock", bus.locked, 1'b1);
        chk8("pd4_mid", {5'd0, bus.match_id}, 8'd6);

        // sylvester with 8-bit wrap
        restart();
        sample(8'd2);   chk8("sy1_cand", bus.cand, 8'hA0);
        sample(8'd3);   chk8("sy2_cand", bus.cand, 8'h80);
        sample(8'd7);   chk8("sy3_cand", bus.cand, 8'h80);  chk1("sy3_lock", bus.locked, 1'b0);
        sample(8'd43);  chk1("sy4_lock", bus.locked, 1'b1); chk8("sy4_mid", {5'd0, bus.match_id}, 8'd7);
        sample(8'd15);  chk8("sy5_cand", bus.cand, 8'h80);  chk1("sy5_fail", bus.fail, 1'b0);
        sample(8'd211); chk8("sy6_cand", bus.cand, 8'h80);  chk1("sy6_lock", bus.locked, 1'b1);
        chk1("sy6_fail", bus.fail, 1'b0);                   chk8("sy6_count", bus.count, 8'd6);

        // no match, sticky fail
        restart();
        sample(8'd0);  sample(8'd1);  sample(8'd5);
        chk8("nm_cand", bus.cand, 8'h00);  chk1("nm_fail", bus.fail, 1'b1);
        chk8("nm_count", bus.count, 8'd3); chk1("nm_lock", bus.locked, 1'b0);
        sample(8'd9);  sample(8'd16);
        chk8("nm_frozen", bus.count, 8'd3); chk1("nm_sticky", bus.fail, 1'b1);
        restart();     chk_idle("st2");

        // lock loss
        sample(8'd2);  sample(8'd1);  sample(8'd3);  sample(8'd4);
        chk1("lu_lock", bus.locked, 1'b1);  chk8("lu_mid", {5'd0, bus.match_id}, 8'd5);
        chk8("lu_cand", bus.cand, 8'h20);
        sample(8'd8);
        chk1("ll_lock", bus.locked, 1'b0);  chk1("ll_fail", bus.fail, 1'b1);
        chk8("ll_mid", {5'd0, bus.match_id}, 8'd0);  chk8("ll_cand", bus.cand, 8'h00);

        // start beats a simultaneous valid sample
        @(negedge clk);
        bus.start = 1'b1;  bus.in_valid = 1'b1;  bus.in_data = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;  bus.in_valid = 1'b0;
        chk_idle("col");

        // async reset mid-cycle
        sample(8'd0);  sample(8'd1);
        chk8("pre_cand", bus.cand, 8'h15);  chk8("pre_count", bus.count, 8'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_idle("arst");
        @(negedge clk);
        reset = 1'b0;
        sample(8'd1);  chk8("ar1_cand", bus.cand, 8'h4A);
        sample(8'd3);  chk8("ar2_cand", bus.cand, 8'h02);  chk8("ar2_count", bus.count, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
